// File: rtl/reg_write_pkg.sv
// reg_write_pkg: shared FSM state type and write-counter constants for reg_write_ctrl.
package reg_write_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

    localparam int WR_COUNT_W = 8;
    localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = 8'd255;

    function automatic int debounce_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/reg_write_ctrl_button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-count debouncer and one-cycle
// registered pulse on each rising edge of the debounced level.
module button_debounce
    import reg_write_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic differ, expired;

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        differ  = sync_q[1] != level_q;
        expired = differ && (cnt_q == CNT_LAST);
        cnt_d   = (differ && !expired) ? cnt_q + 1'b1 : '0;
        level_d = expired ? sync_q[1] : level_q;
        prev_d  = level_q;
        rise_d  = level_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: debounced buttons to single-cycle register-file writes and clear sweeps.
// Define REG_WRITE_AUTO_INC_EN to target an internal auto-incrementing pointer instead of sw_addr.
module reg_write_ctrl
    import reg_write_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_wr,
    input  logic                  btn_clr,
    input  logic [DATA_W-1:0]     sw_data,
    input  logic [ADDR_W-1:0]     sw_addr,
    output logic                  we,
    output logic [ADDR_W-1:0]     waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  busy,
    output logic [WR_COUNT_W-1:0] wr_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e state_q, state_d;
    logic we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic busy_q, busy_d;
    logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
    logic wr_pulse, clr_pulse;
    logic [ADDR_W-1:0] target;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_wr),
        .rise  (wr_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .rise  (clr_pulse)
    );

`ifdef REG_WRITE_AUTO_INC_EN
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE)
            ptr_d = clr_pulse ? '0 : wr_pulse ? ptr_q + 1'b1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign target = ptr_q;
`else
    assign target = sw_addr;
`endif

    // Outputs are computed alongside the next state so they are registered with it.
    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = '0;
        busy_d     = 1'b0;
        wr_count_d = wr_count_q;
        case (state_q)
            IDLE: begin
                if (clr_pulse) begin
                    state_d    = CLEAR;
                    we_d       = 1'b1;
                    waddr_d    = '0;
                    busy_d     = 1'b1;
                    wr_count_d = '0;
                end else if (wr_pulse) begin
                    state_d    = WRITE;
                    we_d       = 1'b1;
                    waddr_d    = target;
                    wdata_d    = sw_data;
                    wr_count_d = (wr_count_q == WR_COUNT_MAX) ? WR_COUNT_MAX : wr_count_q + 1'b1;
                end
            end
            WRITE: state_d = IDLE;
            CLEAR: begin
                if (waddr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb_reg_write_ctrl: directed table, corner sequences and random stimulus against a latency-level model.
module tb_reg_write_ctrl;

    localparam int D = 4;
`ifdef REG_WRITE_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk, rst_n, btn_wr, btn_clr;
    logic [3:0] sw_data;
    logic [2:0] sw_addr;
    logic we, busy;
    logic [2:0] waddr;
    logic [3:0] wdata;
    logic [7:0] wr_count;

    reg_write_ctrl #(.DATA_W(4), .ADDR_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .btn_wr   (btn_wr),
        .btn_clr  (btn_clr),
        .sw_data  (sw_data),
        .sw_addr  (sw_addr),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] wlog[$];
    int nbusy;

    // Model: raw sample history per button, latency pipe for accepted presses,
    // and a sweep position / post-write flag for the controller's busy windows.
    bit [15:0] hw, hc;
    bit lw, lc;
    bit [1:0] pw, pc;
    int spos;
    bit wlast;
    logic m_we, m_busy;
    logic [2:0] m_waddr, m_ptr;
    logic [3:0] m_wdata;
    logic [7:0] m_cnt;

    typedef struct {
        logic [3:0] d;
        logic [2:0] a;
        logic [2:0] ea;
        logic [7:0] ecnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hw = '0; hc = '0; lw = 0; lc = 0; pw = '0; pc = '0;
        spos = -1; wlast = 0;
        m_we = 0; m_busy = 0; m_waddr = '0; m_ptr = '0; m_wdata = '0; m_cnt = '0;
    endfunction

    function automatic void model_edge();
        bit act_w, act_c, rw, rc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        act_w = pw[1];
        act_c = pc[1];
        rw = 0;
        rc = 0;
        if (!lw && (&hw[D:1])) begin lw = 1; rw = 1; end
        else if (lw && !(|hw[D:1])) lw = 0;
        if (!lc && (&hc[D:1])) begin lc = 1; rc = 1; end
        else if (lc && !(|hc[D:1])) lc = 0;
        pw = {pw[0], rw};
        pc = {pc[0], rc};
        hw = {hw[14:0], btn_wr};
        hc = {hc[14:0], btn_clr};
        m_we = 0;
        m_wdata = '0;
        m_busy = 0;
        if (spos >= 0) begin
            if (spos < 7) begin
                spos++;
                m_we = 1;
                m_busy = 1;
                m_waddr = 3'(spos);
            end else begin
                spos = -1;
            end
        end else if (wlast) begin
            wlast = 0;
        end else if (act_c) begin
            spos = 0;
            m_we = 1;
            m_busy = 1;
            m_waddr = '0;
            m_cnt = '0;
            m_ptr = '0;
        end else if (act_w) begin
            wlast = 1;
            m_we = 1;
            m_waddr = AUTO ? m_ptr : sw_addr;
            m_wdata = sw_data;
            m_cnt = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
            m_ptr = m_ptr + 3'd1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("outputs", {15'd0, we, waddr, wdata, busy, wr_count},
            {15'd0, m_we, m_waddr, m_wdata, m_busy, m_cnt});
        if (we) wlog.push_back({waddr, wdata});
        if (busy) nbusy++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int hi, input int lo);
        btn_wr = 1;
        run(hi);
        btn_wr = 0;
        run(lo);
    endtask

    initial begin
        int lat, seen, hw_left, hc_left;
        tbl[0] = '{4'h0, 3'd0, 3'd0, 8'd0};
        tbl[1] = '{4'hF, 3'd7, 3'd0, 8'd0};
        tbl[2] = '{4'h5, 3'd2, 3'd0, 8'd0};
        tbl[3] = '{4'hA, 3'd5, 3'd0, 8'd0};
        tbl[4] = '{4'h1, 3'd1, 3'd0, 8'd0};
        tbl[5] = '{4'h8, 3'd6, 3'd0, 8'd0};
        tbl[6] = '{4'h3, 3'd3, 3'd0, 8'd0};
        tbl[7] = '{4'hC, 3'd4, 3'd0, 8'd0};
        for (int i = 0; i < 8; i++) begin
            tbl[i].ea = AUTO ? 3'(i) : tbl[i].a;
            tbl[i].ecnt = 8'(i + 1);
        end
        rst_n = 0; btn_wr = 0; btn_clr = 0; sw_data = '0; sw_addr = '0;
        model_reset();
        nbusy = 0;

        run(3);
        chk("reset_outputs", {15'd0, we, waddr, wdata, busy, wr_count}, 32'd0);
        rst_n = 1;
        wlog.delete(); nbusy = 0;
        run(50);
        chk("idle_we", wlog.size(), 0);
        chk("idle_busy", nbusy, 0);

        sw_data = 4'hA; sw_addr = 3'd5;
        for (int i = 0; i < 20; i++) begin
            btn_wr = ~i[1];
            step();
        end
        btn_wr = 1;
        wlog.delete();
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (we && lat < 0) lat = k;
        end
        chk("wr_latency", lat, D + 3);
        chk("wr_single_pulse", wlog.size(), 1);
        chk("wr_addr", wlog.size() > 0 ? wlog[0][6:4] : 3'bx, AUTO ? 3'd0 : 3'd5);
        chk("wr_data", wlog.size() > 0 ? wlog[0][3:0] : 4'bx, 4'hA);
        chk("wr_count_1", wr_count, 1);
        btn_wr = 0; run(10);
        btn_wr = 1; run(30);
        chk("second_press_total", wlog.size(), 2);
        chk("wr_count_2", wr_count, 2);
        btn_wr = 0; run(10);

        wlog.delete(); nbusy = 0;
        btn_clr = 1; run(2);
        btn_wr = 1; run(38);
        btn_clr = 0; btn_wr = 0; run(20);
        chk("clr_pulses", wlog.size(), 8);
        for (int i = 0; i < wlog.size() && i < 8; i++)
            chk("clr_entry", wlog[i], {3'(i), 4'h0});
        chk("clr_busy_cycles", nbusy, 8);
        chk("clr_wr_count", wr_count, 0);

        press(6, 10);
        chk("pre_same_count", wr_count, 1);
        wlog.delete(); nbusy = 0;
        btn_wr = 1; btn_clr = 1; run(30);
        btn_wr = 0; btn_clr = 0; run(20);
        chk("same_cycle_pulses", wlog.size(), 8);
        chk("same_cycle_busy", nbusy, 8);
        chk("same_cycle_count", wr_count, 0);

        btn_clr = 1;
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            step();
            if (we) seen = 1;
        end
        chk("sweep_start", seen, 1);
        run(2);
        chk("third_sweep_addr", {busy, waddr}, {1'b1, 3'd2});
        rst_n = 0; btn_clr = 0;
        wlog.delete(); nbusy = 0;
        run(3);
        rst_n = 1;
        run(20);
        chk("abort_writes", wlog.size(), 0);
        chk("abort_busy", nbusy, 0);

        for (int i = 0; i < 8; i++) begin
            sw_data = tbl[i].d;
            sw_addr = tbl[i].a;
            wlog.delete();
            press(6, 8);
            chk("tbl_pulses", wlog.size(), 1);
            chk("tbl_write", wlog.size() > 0 ? wlog[0] : 7'bx, {tbl[i].ea, tbl[i].d});
            chk("tbl_count", wr_count, tbl[i].ecnt);
        end

        repeat (250) press(6, 6);
        chk("wr_count_sat", wr_count, 255);

        hw_left = 0; hc_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hw_left == 0) begin btn_wr = 1'($urandom_range(0, 1)); hw_left = $urandom_range(1, 10); end
            if (hc_left == 0) begin btn_clr = 1'($urandom_range(0, 1)); hc_left = $urandom_range(1, 12); end
            hw_left--; hc_left--;
            sw_data = 4'($urandom);
            sw_addr = 3'($urandom);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1; btn_wr = 0; btn_clr = 0;
        run(20);

`ifdef REG_WRITE_AUTO_INC_EN
        btn_clr = 1; run(20);
        btn_clr = 0; run(20);
        wlog.delete();
        repeat (9) press(6, 6);
        chk("auto_pulses", wlog.size(), 9);
        for (int i = 0; i < wlog.size() && i < 9; i++)
            chk("auto_addr", wlog[i][6:4], 3'(i % 8));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
